// File: rtl/ram_bist_pkg.sv
// Shared types and constants for the RAM march BIST controller.
package ram_bist_pkg;

  // Controller states; the march phases run in declaration order.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR_P  = 3'd1,
    ST_RD_P  = 3'd2,
    ST_WR_N  = 3'd3,
    ST_RD_N  = 3'd4,
    ST_DRAIN = 3'd5,
    ST_DONE  = 3'd6
  } bist_state_t;

  // Background pattern written in the first phase; its inverse goes in the third.
  localparam logic [31:0] DEFAULT_PATTERN = 32'hA5A5_5A5A;

  // Phase tag carried with each read so a failure can be attributed.
  localparam logic PHASE_PAT = 1'b0;
  localparam logic PHASE_INV = 1'b1;

endpackage

// File: rtl/ram_bist_cmp.sv
// Read-data compare pipeline: tracks the read in flight, compares the RAM
// output one cycle later and accumulates the error count and first failure.
module ram_bist_cmp
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_issue,
  input  logic [DATA_W-1:0] exp_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              phase_in,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic              clear,
  input  logic              flush,
  output logic [ADDR_W+1:0] err_count,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic              first_fail_phase
);

  localparam logic [ADDR_W+1:0] ERR_ONE = {{(ADDR_W+1){1'b0}}, 1'b1};

  logic              vld_q, vld_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              phase_q, phase_d;
  logic [ADDR_W+1:0] err_count_q, err_count_d;
  logic [ADDR_W-1:0] ffa_q, ffa_d;
  logic              ffp_q, ffp_d;
  logic              mismatch;

  // A flushed (aborted) compare must not reach the error counter.
  assign mismatch = vld_q && !flush && (ram_dout != exp_q);

  // Next-state for the in-flight read tag and the result registers.
  always_comb begin
    vld_d       = rd_issue && !flush && !clear;
    exp_d       = exp_q;
    addr_d      = addr_q;
    phase_d     = phase_q;
    err_count_d = err_count_q;
    ffa_d       = ffa_q;
    ffp_d       = ffp_q;
    if (rd_issue) begin
      exp_d   = exp_in;
      addr_d  = addr_in;
      phase_d = phase_in;
    end
    if (clear) begin
      err_count_d = '0;
      ffa_d       = '0;
      ffp_d       = PHASE_PAT;
    end else if (mismatch) begin
      err_count_d = err_count_q + ERR_ONE;
      if (err_count_q == '0) begin
        ffa_d = addr_q;
        ffp_d = phase_q;
      end
    end
  end

  // Register stage with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= 1'b0;
      exp_q       <= '0;
      addr_q      <= '0;
      phase_q     <= PHASE_PAT;
      err_count_q <= '0;
      ffa_q       <= '0;
      ffp_q       <= PHASE_PAT;
    end else begin
      vld_q       <= vld_d;
      exp_q       <= exp_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      err_count_q <= err_count_d;
      ffa_q       <= ffa_d;
      ffp_q       <= ffp_d;
    end
  end

  assign err_count        = err_count_q;
  assign first_fail_addr  = ffa_q;
  assign first_fail_phase = ffp_q;

endmodule

// File: rtl/ram_bist.sv
// March BIST controller for a single-port RAM: write pattern, read pattern,
// write inverse, read inverse descending, then report the results.
module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int                ADDR_W  = 5,
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] PATTERN = DATA_W'(DEFAULT_PATTERN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W+1:0] err_count,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic              first_fail_phase,
  output logic              ram_cen,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  bist_state_t       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              start_ok;
  logic              rd_issue;

  assign busy     = (state_q == ST_WR_P) || (state_q == ST_RD_P) || (state_q == ST_WR_N) ||
                    (state_q == ST_RD_N) || (state_q == ST_DRAIN);
  assign done     = (state_q == ST_DONE);
  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign rd_issue = (state_q == ST_RD_P) || (state_q == ST_RD_N);

  // Phase sequencing and address counter; abort overrides any advance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_WR_P;
          cnt_d   = '0;
        end
      end
      ST_WR_P: begin
        if (cnt_q == ADDR_MAX) begin
          state_d = ST_RD_P;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_ONE;
        end
      end
      ST_RD_P: begin
        if (cnt_q == ADDR_MAX) begin
          state_d = ST_WR_N;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_ONE;
        end
      end
      ST_WR_N: begin
        if (cnt_q == ADDR_MAX) begin
          state_d = ST_RD_N;
          cnt_d   = ADDR_MAX;
        end else begin
          cnt_d = cnt_q + ADDR_ONE;
        end
      end
      ST_RD_N: begin
        if (cnt_q == '0) begin
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q - ADDR_ONE;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
    if (busy && abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // RAM pin decode, driven only from registered state so start/abort never reach the pins.
  always_comb begin
    ram_cen  = 1'b0;
    ram_wen  = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    unique case (state_q)
      ST_WR_P: begin
        ram_cen  = 1'b1;
        ram_wen  = 1'b1;
        ram_addr = cnt_q;
        ram_din  = PATTERN;
      end
      ST_RD_P, ST_RD_N: begin
        ram_cen  = 1'b1;
        ram_addr = cnt_q;
      end
      ST_WR_N: begin
        ram_cen  = 1'b1;
        ram_wen  = 1'b1;
        ram_addr = cnt_q;
        ram_din  = ~PATTERN;
      end
      default: ;
    endcase
  end

  ram_bist_cmp #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_cmp (
    .clk             (clk),
    .rst             (rst),
    .rd_issue        (rd_issue),
    .exp_in          ((state_q == ST_RD_N) ? ~PATTERN : PATTERN),
    .addr_in         (cnt_q),
    .phase_in        ((state_q == ST_RD_N) ? PHASE_INV : PHASE_PAT),
    .ram_dout        (ram_dout),
    .clear           (start_ok),
    .flush           (busy && abort),
    .err_count       (err_count),
    .first_fail_addr (first_fail_addr),
    .first_fail_phase(first_fail_phase)
  );

  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: behavioural RAM with injectable read faults, schedule
// checks on the pins, and a march-level model of the expected results.
module tb_ram_bist;

  localparam logic [31:0] PAT = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic        busy, done, pass, first_fail_phase;
  logic [6:0]  err_count;
  logic [4:0]  first_fail_addr;
  logic        ram_cen, ram_wen;
  logic [4:0]  ram_addr;
  logic [31:0] ram_din, ram_dout;

  int n_tests = 0;
  int n_fail  = 0;

  // Fault tables: or_mask models stuck-at-1 bits per address (both phases);
  // xor_tab[phase][addr] flips read bits only in the given read phase.
  logic [31:0] or_mask [32];
  logic [31:0] xor_tab [2][32];

  logic [31:0] mem [32];
  logic [31:0] raw_q;
  logic [4:0]  ra_q;
  logic        rp_q;

  always #5 clk = ~clk;

  ram_bist dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_addr(first_fail_addr), .first_fail_phase(first_fail_phase),
    .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Single-port RAM with one-cycle read latency; read phase inferred from stored data.
  always @(posedge clk) begin
    if (ram_cen && ram_wen) mem[ram_addr] <= ram_din;
    if (ram_cen && !ram_wen) begin
      raw_q <= mem[ram_addr];
      ra_q  <= ram_addr;
      rp_q  <= (mem[ram_addr] == ~PAT);
    end
  end

  assign ram_dout = (raw_q | or_mask[ra_q]) ^ xor_tab[rp_q][ra_q];

  task automatic clear_faults();
    for (int a = 0; a < 32; a++) begin
      or_mask[a]    = '0;
      xor_tab[0][a] = '0;
      xor_tab[1][a] = '0;
    end
  endtask

  // March-level expectation: walk the two read phases in march order and apply faults.
  task automatic model_expect(output int ec, output int fa, output int fp);
    logic [31:0] expw, obs;
    int a;
    ec = 0; fa = 0; fp = 0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 32; i++) begin
        a    = (p == 0) ? i : 31 - i;
        expw = (p == 0) ? PAT : ~PAT;
        obs  = (expw | or_mask[a]) ^ xor_tab[p][a];
        if (obs != expw) begin
          if (ec == 0) begin fa = a; fp = p; end
          ec++;
        end
      end
    end
  endtask

  // Pulse start, then follow cycles T+1..T+130 checking the pins against the
  // march schedule; optionally inject start/abort/rst in a given cycle.
  task automatic do_march(input int abort_k, input int start_k, input int rst_k,
                          output int bad, output int wr_n, output int rd_n,
                          output logic [6:0] err_k1, output logic [4:0] ffa_k1);
    logic        e_cen, e_wen;
    logic [4:0]  e_addr;
    logic [31:0] e_din;
    bad = 0; wr_n = 0; rd_n = 0; err_k1 = '0; ffa_k1 = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= 130; k++) begin
      e_cen = 1'b0; e_wen = 1'b0; e_addr = '0; e_din = '0;
      if (k <= 32) begin
        e_cen = 1'b1; e_wen = 1'b1; e_addr = 5'(k - 1); e_din = PAT;
      end else if (k <= 64) begin
        e_cen = 1'b1; e_addr = 5'(k - 33);
      end else if (k <= 96) begin
        e_cen = 1'b1; e_wen = 1'b1; e_addr = 5'(k - 65); e_din = ~PAT;
      end else if (k <= 128) begin
        e_cen = 1'b1; e_addr = 5'(128 - k);
      end
      if ({busy, done, ram_cen, ram_wen, ram_addr, ram_din} !==
          {(k <= 129), (k == 130), e_cen, e_wen, e_addr, e_din}) bad++;
      if (ram_cen === 1'b1 && ram_wen === 1'b1) wr_n++;
      if (ram_cen === 1'b1 && ram_wen === 1'b0) rd_n++;
      if (k == 1) begin err_k1 = err_count; ffa_k1 = first_fail_addr; end
      if (k == 130) break;
      if (k == start_k) start = 1'b1;
      if (k == abort_k) abort = 1'b1;
      if (k == rst_k)   rst   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (k == abort_k || k == rst_k) begin
        abort = 1'b0;
        rst   = 1'b0;
        break;
      end
    end
    $display("[TB] march: bad_cycles=%0d writes=%0d reads=%0d err=%0d ffa=%0d ffp=%0d done=%0b",
             bad, wr_n, rd_n, err_count, first_fail_addr, first_fail_phase, done);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({busy, done, pass, err_count, first_fail_addr, first_fail_phase} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_status: got busy=%b done=%b pass=%b err=%0d ffa=%0d ffp=%b, want all 0",
               busy, done, pass, err_count, first_fail_addr, first_fail_phase);
    end
    n_tests++;
    if ({ram_cen, ram_wen, ram_addr, ram_din} !== 39'h0) begin
      n_fail++;
      $display("FAIL reset_pins: got cen=%b wen=%b addr=%0d din=%h, want all 0",
               ram_cen, ram_wen, ram_addr, ram_din);
    end
  endtask

  task automatic test_fault_free();
    int bad, wr_n, rd_n;
    logic [6:0] e1;
    logic [4:0] a1;
    clear_faults();
    do_march(0, 0, 0, bad, wr_n, rd_n, e1, a1);
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL ff_schedule: %0d bad cycles, want 0", bad); end
    n_tests++;
    if (wr_n != 64 || rd_n != 64) begin
      n_fail++; $display("FAIL ff_counts: writes=%0d reads=%0d, want 64/64", wr_n, rd_n);
    end
    n_tests++;
    if (pass !== 1'b1 || err_count !== 7'd0) begin
      n_fail++; $display("FAIL ff_result: pass=%b err=%0d, want 1/0", pass, err_count);
    end
  endtask

  task automatic test_stuck_at();
    int bad, wr_n, rd_n;
    logic [6:0] e1;
    logic [4:0] a1;
    clear_faults();
    or_mask[7] = 32'h1;
    do_march(0, 0, 0, bad, wr_n, rd_n, e1, a1);
    n_tests++;
    if (err_count !== 7'd1 || first_fail_addr !== 5'd7 || first_fail_phase !== 1'b0 ||
        pass !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL stuck_at: err=%0d ffa=%0d ffp=%b pass=%b done=%b, want 1/7/0/0/1",
               err_count, first_fail_addr, first_fail_phase, pass, done);
    end
  endtask

  task automatic test_inverse_faults();
    int bad, wr_n, rd_n;
    logic [6:0] e1;
    logic [4:0] a1;
    clear_faults();
    xor_tab[1][31] = 32'h1 << $urandom_range(0, 31);
    xor_tab[1][0]  = 32'h1 << $urandom_range(0, 31);
    do_march(0, 0, 0, bad, wr_n, rd_n, e1, a1);
    n_tests++;
    if (err_count !== 7'd2 || first_fail_addr !== 5'd31 || first_fail_phase !== 1'b1 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL inverse_faults: err=%0d ffa=%0d ffp=%b pass=%b, want 2/31/1/0",
               err_count, first_fail_addr, first_fail_phase, pass);
    end
  endtask

  task automatic test_random_faults();
    int bad, wr_n, rd_n, ec, fa, fp;
    logic [6:0] e1;
    logic [4:0] a1;
    for (int it = 0; it < 6; it++) begin
      clear_faults();
      for (int a = 0; a < 32; a++) begin
        if ($urandom_range(0, 15) == 0) or_mask[a] = 32'h1 << $urandom_range(0, 31);
        if ($urandom_range(0, 9) == 0) xor_tab[0][a] = 32'h1 << $urandom_range(0, 31);
        if ($urandom_range(0, 9) == 0) xor_tab[1][a] = 32'h1 << $urandom_range(0, 31);
      end
      model_expect(ec, fa, fp);
      do_march(0, 0, 0, bad, wr_n, rd_n, e1, a1);
      n_tests++;
      if (err_count !== 7'(ec) || first_fail_addr !== 5'(fa) || first_fail_phase !== 1'(fp) ||
          pass !== (ec == 0) || bad != 0) begin
        n_fail++;
        $display("FAIL random_%0d: err=%0d ffa=%0d ffp=%b pass=%b bad=%0d, want %0d/%0d/%0d/%0b/0",
                 it, err_count, first_fail_addr, first_fail_phase, pass, bad, ec, fa, fp, (ec == 0));
      end
    end
  endtask

  task automatic test_abort_restart();
    int bad, wr_n, rd_n;
    logic [6:0] e1;
    logic [4:0] a1;
    clear_faults();
    xor_tab[0][3] = 32'h10;
    do_march(40, 0, 0, bad, wr_n, rd_n, e1, a1);
    n_tests++;
    if (bad != 0 || busy !== 1'b0 || done !== 1'b0 || ram_cen !== 1'b0 || ram_wen !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: bad=%0d busy=%b done=%b cen=%b wen=%b, want 0/0/0/0/0",
               bad, busy, done, ram_cen, ram_wen);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: busy=%b done=%b, want 0/0", busy, done);
    end
    clear_faults();
    do_march(0, 0, 0, bad, wr_n, rd_n, e1, a1);
    n_tests++;
    if (bad != 0 || pass !== 1'b1 || err_count !== 7'd0) begin
      n_fail++;
      $display("FAIL restart_after_abort: bad=%0d pass=%b err=%0d, want 0/1/0", bad, pass, err_count);
    end
  endtask

  task automatic test_reset_mid();
    int bad, wr_n, rd_n;
    logic [6:0] e1;
    logic [4:0] a1;
    clear_faults();
    xor_tab[0][5] = 32'h100;
    do_march(0, 50, 100, bad, wr_n, rd_n, e1, a1);
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL busy_start_ignored: %0d bad cycles before reset, want 0", bad);
    end
    n_tests++;
    if ({busy, done, pass, err_count, first_fail_addr, first_fail_phase,
         ram_cen, ram_wen, ram_addr, ram_din} !== 55'h0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b err=%0d ffa=%0d ffp=%b cen=%b addr=%0d din=%h, want all 0",
               busy, done, err_count, first_fail_addr, first_fail_phase, ram_cen, ram_addr, ram_din);
    end
  endtask

  task automatic test_back_to_back();
    int bad, wr_n, rd_n, ec, fa, fp;
    logic [6:0] e1;
    logic [4:0] a1;
    clear_faults();
    xor_tab[0][9] = 32'h8000_0000;
    do_march(0, 0, 0, bad, wr_n, rd_n, e1, a1);
    n_tests++;
    if (err_count !== 7'd1 || first_fail_addr !== 5'd9 || first_fail_phase !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first: err=%0d ffa=%0d ffp=%b, want 1/9/0", err_count, first_fail_addr, first_fail_phase);
    end
    clear_faults();
    xor_tab[1][20] = 32'h8;
    model_expect(ec, fa, fp);
    do_march(0, 0, 0, bad, wr_n, rd_n, e1, a1);
    n_tests++;
    if (e1 !== 7'd0 || a1 !== 5'd0 || bad != 0) begin
      n_fail++;
      $display("FAIL b2b_clear: err@T+1=%0d ffa@T+1=%0d bad=%0d, want 0/0/0", e1, a1, bad);
    end
    n_tests++;
    if (err_count !== 7'(ec) || first_fail_addr !== 5'(fa) || first_fail_phase !== 1'(fp)) begin
      n_fail++;
      $display("FAIL b2b_second: err=%0d ffa=%0d ffp=%b, want %0d/%0d/%0d",
               err_count, first_fail_addr, first_fail_phase, ec, fa, fp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    clear_faults();
    test_reset();
    test_fault_free();
    test_stuck_at();
    test_inverse_faults();
    test_random_faults();
    test_abort_restart();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
